// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, drives ADDR_Prog and presents fetched words to decode.
// Latency: first word valid 2 edges after start; 1 word/cycle after that; 1 bubble per branch.
// Backpressure: stall with a valid word replays its address so mem_data holds; optional
// counters are enabled with `define FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 10,
  parameter int                  PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] START_ADDR = 16'h1030,
  parameter logic [PC_WIDTH-1:0] END_ADDR   = 16'h1049
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic [ADDR_WIDTH-1:0] ADDR_Prog,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]   instr_pc,
  output logic                  instr_valid,
  output logic                  busy,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_cycles,
`endif
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] infl_pc;
  logic                infl_v;

  logic in_fetch;
  logic do_start;
  logic hold;
  logic past_end;

  assign in_fetch = (state == FETCH);
  // start is only honoured outside FETCH
  assign do_start = start & (state != FETCH);
  // a presented word that decode refuses is kept and its address re-read
  assign hold     = stall & infl_v;
  assign past_end = (pc_q > END_ADDR);

  // Address mux: replay the presented word's address while stalled, else the next PC.
  // Upper PC bits are dropped on purpose; the memory applies its own base offset.
  assign ADDR_Prog   = hold ? infl_pc[ADDR_WIDTH-1:0] : pc_q[ADDR_WIDTH-1:0];
  assign instr_out   = mem_data;
  assign instr_pc    = infl_pc;
  assign instr_valid = infl_v;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: branch beyond the program or running off the end finishes the run
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (branch_en) begin
          if (branch_target > END_ADDR) state_nxt = DONE;
        end else if (!hold && past_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == FETCH);
    done = (state == DONE);
  end

  // PC / in-flight tracking: branch squashes (even over stall), stall holds, else issue pc_q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= START_ADDR;
      infl_v  <= 1'b0;
      infl_pc <= START_ADDR;
    end else if (do_start) begin
      pc_q   <= START_ADDR;
      infl_v <= 1'b0;
    end else if (in_fetch) begin
      if (branch_en) begin
        pc_q   <= branch_target;
        infl_v <= 1'b0;
      end else if (!hold) begin
        if (!past_end) begin
          infl_v  <= 1'b1;
          infl_pc <= pc_q;
          pc_q    <= pc_q + PC_ONE;
        end else begin
          infl_v <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Saturating counters of accepted words and stalled-with-valid FETCH cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count  <= 32'd0;
      stall_cycles <= 32'd0;
    end else if (do_start) begin
      fetch_count  <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      if (in_fetch && infl_v && !stall && (fetch_count != CNT_MAX))
        fetch_count <= fetch_count + 32'd1;
      if (in_fetch && hold && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: random stall/branch stimulus, expected fetch stream
// built from the program range and branch plan, checked by a monitor on every accept.
module tb_instruction_fetch_unit;

  localparam int START = 16'h1030;
  localparam int END_A = 16'h1049;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic [9:0]  ADDR_Prog;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        busy;
  logic        done;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_cycles;
`endif

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_target(branch_target),
    .ADDR_Prog(ADDR_Prog), .mem_data(mem_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .busy(busy),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle registered read; word 0 sits at address 0x030
  logic [31:0] mem [0:1023];
  always @(posedge clk) mem_data <= mem[ADDR_Prog - 10'h030];

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   stl_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_at(input int pc);
    logic [9:0] idx;
    idx = 10'(pc - START);
    return mem[idx];
  endfunction

  task automatic push_range(input int a, input int b);
    exp_t e;
    for (int p = a; p <= b; p++) begin
      e.pc  = 16'(p);
      e.dat = mem_at(p);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must be the next expected one; stalled words must replay
  always @(negedge clk) begin
    if (rst && instr_valid) begin
      if (stall) begin
        chk("addr_replay", {22'b0, ADDR_Prog}, {22'b0, instr_pc[9:0]});
        if (busy) stl_cnt++;
      end else begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got pc 0x%0h, expected no word", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("acc_pc", {16'b0, instr_pc}, {16'b0, mon_e.pc});
          chk("acc_dat", instr_out, mon_e.dat);
        end
      end
    end
  end

  // One program run: bp<0 means no branch, early branches in the first FETCH cycle,
  // hold_pc gets a 3-cycle stall when it is presented.
  task automatic run(input int bp, input int tgt, input int stall_pct, input int hold_pc,
                     input bit early);
    int a0, s0, nhold;
    bit branched, bub, tchk, fin;
    if (early) push_range(tgt, END_A);
    else if (bp >= 0) begin
      push_range(START, bp - 1);
      push_range(tgt, END_A);
    end else push_range(START, END_A);
    a0 = acc_cnt; s0 = stl_cnt; nhold = 0;
    branched = early; bub = 0; tchk = 0; fin = 0;

    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("first_cycle_invalid", {31'b0, instr_valid}, 32'd0);
    chk("first_addr", {22'b0, ADDR_Prog}, 32'h030);
    stall = ($urandom_range(0, 99) < stall_pct);
    if (early) begin
      branch_en = 1'b1;
      branch_target = 16'(tgt);
    end
    step();
    if (early) bub = 1;
    else begin
      chk("first_valid", {31'b0, instr_valid}, 32'd1);
      chk("first_pc", {16'b0, instr_pc}, START);
      chk("first_dat", instr_out, mem_at(START));
    end

    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      if (tchk) begin
        chk("target_valid", {31'b0, instr_valid}, 32'd1);
        chk("target_pc", {16'b0, instr_pc}, 32'(tgt));
        tchk = 0;
      end
      if (bub) begin
        chk("branch_bubble", {31'b0, instr_valid}, 32'd0);
        bub = 0;
        tchk = (tgt <= END_A);
      end
      if (done) fin = 1;
      else begin
        branch_en = 1'b0;
        stall = ($urandom_range(0, 99) < stall_pct);
        if (!branched && bp >= 0 && instr_valid && instr_pc == 16'(bp)) begin
          stall = 1'b1;
          branch_en = 1'b1;
          branch_target = 16'(tgt);
          branched = 1;
          bub = 1;
        end else if (hold_pc >= 0 && instr_valid && instr_pc == 16'(hold_pc) && nhold < 3) begin
          stall = 1'b1;
          nhold++;
        end
        step();
      end
    end
    stall = 1'b0;
    branch_en = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: got no done within 500 cycles, expected done");
      rst = 1'b0;
      step();
      rst = 1'b1;
      exp_q.delete();
      return;
    end
    chk("done_flag", {31'b0, done}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    chk("valid_at_done", {31'b0, instr_valid}, 32'd0);
    chk("words_left", exp_q.size(), 32'd0);
    exp_q.delete();
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, 32'(acc_cnt - a0));
    chk("stall_cycles", stall_cycles, 32'(stl_cnt - s0));
`endif
    // branch and stall have no effect in DONE
    branch_en = 1'b1;
    branch_target = 16'(START);
    stall = 1'b1;
    step();
    step();
    branch_en = 1'b0;
    stall = 1'b0;
    chk("done_ignores_branch", {31'b0, done}, 32'd1);
    chk("done_no_valid", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    int mode, a_before;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_addr", {22'b0, ADDR_Prog}, 32'h030);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle_no_issue", {31'b0, instr_valid}, 32'd0);

    // Full run with a 3-cycle stall at 0x1033
    a_before = acc_cnt;
    run(-1, 0, 0, 16'h1033, 1'b0);
    chk("words_in_full_run", 32'(acc_cnt - a_before), 32'd26);

    // Stall at 0x1033, then branch to 0x1040 while 0x1034 is stalled (restart from DONE)
    run(16'h1034, 16'h1040, 0, 16'h1033, 1'b0);

    // Asynchronous reset between edges in the middle of a run
    push_range(START, END_A);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_addr", {22'b0, ADDR_Prog}, 32'h030);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) step();
    chk("post_arst_idle", {31'b0, busy}, 32'd0);
    chk("post_arst_novalid", {31'b0, instr_valid}, 32'd0);

    // Randomised runs: random memory (with NOP zeros), stalls and branch plans
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 1024; i++)
        mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      mode = $urandom_range(0, 2);
      run((mode == 1) ? int'($urandom_range(START, END_A)) : -1,
          int'($urandom_range(START, END_A + 3)),
          int'($urandom_range(0, 60)), -1, (mode == 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction memory port. Owns the program counter and drives ADDR_Prog. Absorbs the memory's one-cycle registered read latency and presents a valid/stall handshake to the decode stage. Handles stall replay, branch redirect with squash, and an end-of-program stop.

Parameters:
DATA_WIDTH, 32, instruction word width.
ADDR_WIDTH, 10, instruction memory address width.
PC_WIDTH, 16, program counter width (word-addressed, increments by 1).
START_ADDR, 16'h1030, PC value loaded at reset and on start.
END_ADDR, 16'h1049, last PC issued; 26 words.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins fetch from START_ADDR; honoured in IDLE and DONE only.
stall  in  1  decode stage cannot accept the presented instruction.
branch_en  in  1  redirect request; valid only in FETCH.
branch_target  in  PC_WIDTH  redirect PC.
ADDR_Prog  out  ADDR_WIDTH  memory address.
mem_data  in  DATA_WIDTH  memory data_out; holds mem[address issued on the previous edge].
instr_out  out  DATA_WIDTH  instruction to decode; equals mem_data.
instr_pc  out  PC_WIDTH  PC of instr_out.
instr_valid  out  1  instr_out is valid.
busy  out  1  high in FETCH.
done  out  1  high in DONE.

Behaviour:
- State registers: state {IDLE, FETCH, DONE}, pc_q, infl_v, infl_pc.
- Reset (rst low, asynchronous):
  - state=IDLE, pc_q=START_ADDR, infl_v=0, infl_pc=START_ADDR.
  - Outputs: instr_valid=0, busy=0, done=0.
- ADDR_Prog is combinational:
  - (stall & infl_v) ? infl_pc[ADDR_WIDTH-1:0] : pc_q[ADDR_WIDTH-1:0].
  - Truncation is intentional; the memory applies its own base offset modulo 2**ADDR_WIDTH.
- instr_out=mem_data, instr_pc=infl_pc, instr_valid=infl_v. All are combinational from registers and mem_data.
- An instruction is accepted on an edge where instr_valid=1 and stall=0.
- IDLE:
  - start → FETCH; pc_q=START_ADDR; infl_v=0.
  - Nothing is issued in IDLE.
- FETCH, per edge, in priority order:
  1. branch_en: pc_q<=branch_target; infl_v<=0. This squashes the in-flight word, and squashing takes precedence over stall. branch_target > END_ADDR → DONE.
  2. stall & infl_v: pc_q, infl_v, infl_pc hold. The same address is re-read, so mem_data stays stable.
  3. Otherwise, when pc_q <= END_ADDR: infl_v<=1, infl_pc<=pc_q, pc_q<=pc_q+1.
  4. Otherwise (pc_q > END_ADDR): infl_v<=0, then → DONE.
- Latency:
  - First instr_valid arrives 2 edges after start is sampled.
  - Steady state: 1 instruction per cycle.
  - Branch penalty: 1 invalid cycle. The target instruction is valid 2 edges after branch_en.
- pc_q increment wraps modulo 2**PC_WIDTH. END_ADDR = 2**PC_WIDTH-1 is unsupported.
- DONE:
  - done=1 and infl_v=0.
  - start → FETCH, restarting from START_ADDR.
  - branch_en and stall are ignored.
- Stall while infl_v=0 has no effect; fetch advances normally.
- Reset asserted mid-operation aborts immediately with no partial state retained.
- All-zero words are NOPs and are fetched and presented like any other instruction. The unit does not filter bubbles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - fetch_count (32): increments on each accepted instruction.
  - stall_cycles (32): increments each FETCH cycle with stall & instr_valid.
  - Both clear on rst and on start. They saturate at 32'hFFFFFFFF.
- When undefined, neither port nor counter exists, and the remaining behaviour is identical.

Test Plan:
- Reset, then start, with a memory model holding mem[i]=i+1 → ADDR_Prog issues 0x030, 0x031, ...; instr_valid first high 2 edges after start with instr_out=1, instr_pc=16'h1030; one word per cycle thereafter.
- stall high for 3 cycles while instr_pc=16'h1033 → instr_out/instr_pc held 3 cycles; ADDR_Prog=0x033 during stall; no word lost or duplicated after release.
- branch_en with target 16'h1040 while instr_pc=16'h1034 and stall high → next cycle instr_valid=0; following cycle instr_pc=16'h1040; 0x1035 is never accepted.
- Run to end → last accepted instr_pc=16'h1049; then instr_valid=0 and done=1, busy=0. A start pulse in DONE restarts at 16'h1030.
- Drive rst low mid-FETCH asynchronously, between edges → instr_valid, busy, done go 0 immediately; pc_q=16'h1030; no fetch until the next start.
- With FETCH_PERF_CNT_EN, full 26-word run plus a 3-cycle stall → fetch_count=26, stall_cycles=3.
